// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-port arbiter and access sequencer for the single-ported data RAM.
// It is shared by the CPU datapath and the debug/loader port. Each access takes two
// cycles: ACC drives the RAM, then ACK returns the synchronous read data and the
// completion pulse. Requests are re-arbitrated in ACK, so held requests get back-to-back
// accesses.
//
// Build option:
//   BUS_ARB_RR_EN defined   : round-robin arbitration on contention.
//   BUS_ARB_RR_EN undefined : fixed CPU priority, with DBG forced in after MAX_BURST
//                             consecutive CPU grants under contention.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/wen/addr/wdata    CPU request (wen active-low)
//   cpu_rdata, cpu_ack        CPU completion; rdata valid while ack = 1
//   stall_out                 cpu_req & ~cpu_ack
//   dbg_*                     same as cpu_* for the debug port
//   mem_addr/wdata/wen        RAM strobes (wen active-low), driven only in ACC
//   mem_rdata                 RAM read data, one cycle after address
//   dbg_owner_out             1 when the current or most recent grant is DBG
module mem_bus_arb #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          stall_out,
  input  logic          dbg_req,
  input  logic          dbg_wen,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata,
  output logic          dbg_owner_out
);

  typedef enum logic [1:0] {StIdle, StAcc, StAck} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;      // 1 = DBG, 0 = CPU
  logic [3:0] burst_q, burst_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dbg_ack_q, dbg_ack_d;
`ifdef BUS_ARB_RR_EN
  // Last owner for round-robin; resets to DBG so the CPU wins the first contention.
  logic       rr_last_q, rr_last_d;
`endif

  logic any_req;
  logic win_dbg;
  logic grant_en;

  assign any_req = cpu_req | dbg_req;

  // Arbitration among the requests present this cycle.
  always_comb begin
    win_dbg = dbg_req;
    if (cpu_req && dbg_req) begin
`ifdef BUS_ARB_RR_EN
      win_dbg = ~rr_last_q;
`else
      // Starvation cap: DBG wins once the CPU has used up its burst.
      win_dbg = !owner_q && (burst_q == MaxBurst);
`endif
    end
  end

  assign grant_en = any_req && (state_q == StIdle || state_q == StAck);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
`ifdef BUS_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif

    unique case (state_q)
      StIdle: if (any_req) state_d = StAcc;
      StAcc: begin
        state_d   = StAck;
        cpu_ack_d = ~owner_q;
        dbg_ack_d = owner_q;
      end
      StAck:   state_d = any_req ? StAcc : StIdle;
      default: state_d = StIdle;
    endcase

    if (grant_en) begin
      owner_d = win_dbg;
      if (win_dbg != owner_q) begin
        burst_d = 4'd1;
      end else if (burst_q >= MaxBurst) begin
        burst_d = MaxBurst;
      end else begin
        burst_d = burst_q + 4'd1;
      end
`ifdef BUS_ARB_RR_EN
      rr_last_d = win_dbg;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      burst_q   <= 4'd0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
`ifdef BUS_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
`ifdef BUS_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // RAM strobes are taken straight from the owner's inputs during ACC, so a write
  // cut short by reset in ACC has still been presented to the RAM.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b1;
    if (state_q == StAcc) begin
      mem_addr  = owner_q ? dbg_addr  : cpu_addr;
      mem_wdata = owner_q ? dbg_wdata : cpu_wdata;
      mem_wen   = owner_q ? dbg_wen   : cpu_wen;
    end
  end

  // Ack flops are set only on the ACC->ACK transition, so they are high exactly in ACK.
  assign cpu_ack       = cpu_ack_q;
  assign dbg_ack       = dbg_ack_q;
  assign cpu_rdata     = cpu_ack_q ? mem_rdata : '0;
  assign dbg_rdata     = dbg_ack_q ? mem_rdata : '0;
  assign stall_out     = cpu_req & ~cpu_ack_q;
  assign dbg_owner_out = owner_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wen, dbg_req, dbg_wen;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, stall_out, mem_wen, dbg_owner_out;

  always #5 clk = ~clk;

  mem_bus_arb #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .stall_out     (stall_out),
    .dbg_req       (dbg_req),
    .dbg_wen       (dbg_wen),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_rdata     (dbg_rdata),
    .dbg_ack       (dbg_ack),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wen       (mem_wen),
    .mem_rdata     (mem_rdata),
    .dbg_owner_out (dbg_owner_out)
  );

  // Synchronous-read RAM model with a bench-side preload port.
  logic [15:0] ram [65536];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (!mem_wen) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        dbg;
    logic        chk;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit space_en = 1'b0;
  int last_ack_cyc = -1;

  // Monitor: pops one expectation per ack and checks port, data and spacing.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] rd;
    if (!space_en) last_ack_cyc = -1;
    if (cpu_ack || dbg_ack) begin
      n_chk++;
      rd = dbg_ack ? dbg_rdata : cpu_rdata;
      if (cpu_ack && dbg_ack) begin
        $display("FAIL ack_both: got cpu_ack=1 dbg_ack=1 required one ack");
      end else if (exp_q.size() == 0) begin
        $display("FAIL ack_unexpected: got ack dbg=%0d at cyc %0d required none", dbg_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.dbg !== dbg_ack)
          $display("FAIL ack_port: got dbg=%0d required dbg=%0d", dbg_ack, e.dbg);
        else if (e.chk && rd !== e.data)
          $display("FAIL ack_rdata: got %h required %h", rd, e.data);
        else
          n_pass++;
      end
      if (space_en) begin
        if (last_ack_cyc >= 0) begin
          n_chk++;
          if (cyc - last_ack_cyc == 2) n_pass++;
          else $display("FAIL ack_spacing: got %0d required 2", cyc - last_ack_cyc);
        end
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic push(input logic is_dbg, input logic chk, input logic [15:0] data);
    exp_t e;
    e.dbg  = is_dbg;
    e.chk  = chk;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Single access from IDLE; called just after a rising edge (start of cycle 0).
  task automatic do_access(input logic is_dbg, input logic wen, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rd,
                           input logic chk_rd);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_wen = wen; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    end
    push(is_dbg, chk_rd, exp_rd);
    @(negedge clk);
    check("stall_c0", stall_out, !is_dbg);
    @(negedge clk);
    check("stall_c1", stall_out, !is_dbg);
    check("mem_wen_c1", mem_wen, wen);
    check("mem_addr_c1", mem_addr, addr);
    if (!wen) check("mem_wdata_c1", mem_wdata, wdata);
    check("owner_c1", dbg_owner_out, is_dbg);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    check("stall_c2", stall_out, 1'b0);
    check("ack_c2", is_dbg ? dbg_ack : cpu_ack, 1'b1);
    check("mem_wen_c2", mem_wen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_dbg;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_wen = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_wen = 1'b1; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    preload(16'h0010, 16'hBEEF);
    preload(16'h0003, 16'hA5A5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_dbg_ack", dbg_ack, 1'b0);
    check("rst_mem_wen", mem_wen, 1'b1);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_owner", dbg_owner_out, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    check("rst_dbg_rdata", dbg_rdata, 16'h0);
    check("rst_stall", stall_out, 1'b0);
    @(posedge clk);
    #1;

    do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
    do_access(1'b0, 1'b0, 16'h0020, 16'h1234, 16'h0000, 1'b0);
    do_access(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h1234, 1'b1);
    do_access(1'b1, 1'b1, 16'h0003, 16'h0000, 16'hA5A5, 1'b1);

    // Contention: both held for ten accesses.
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 16'h0010;
    dbg_req = 1'b1; dbg_wen = 1'b1; dbg_addr = 16'h0003;
    space_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef BUS_ARB_RR_EN
      exp_dbg = (i % 2) == 1;
`else
      exp_dbg = (i == 4) || (i == 9);
`endif
      push(exp_dbg, 1'b1, exp_dbg ? 16'hA5A5 : 16'hBEEF);
    end
    repeat (20) @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    space_en = 1'b0;
    check("contention_drained", exp_q.size(), 0);

    // Reset during the ACC cycle of a debug write.
    dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 16'h0040; dbg_wdata = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    check("rw_mem_wen_acc", mem_wen, 1'b0);
    check("rw_mem_addr_acc", mem_addr, 16'h0040);
    check("rw_owner_acc", dbg_owner_out, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dbg_req = 1'b0;
    dbg_wen = 1'b1;
    @(negedge clk);
    check("rw_no_ack", dbg_ack, 1'b0);
    check("rw_mem_wen", mem_wen, 1'b1);
    check("rw_owner", dbg_owner_out, 1'b0);
    check("rw_mem_addr", mem_addr, 16'h0);
    check("rw_ram_written", ram[16'h0040], 16'h5555);
    @(posedge clk);
    #1;

    // Back in IDLE: a fresh read must complete with two-cycle latency.
    do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
    do_access(1'b1, 1'b1, 16'h0040, 16'h0000, 16'h5555, 1'b1);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
